pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Inputs: load-use stall request from the forwarding unit, EX-stage redirect, multi-cycle MDU handshake, data-memory wait.
- Outputs: per-stage register write enables, flushes and the MDU start pulse.
- Keeps saturating stall-cycle counters for performance reporting.

Parameters:
- LOAD_STALL_CYC, 1, bubble cycles inserted per load-use hazard (1..7).
- CNT_W, 32, width of each stall counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_stop  in  1  load-use hazard: ID consumer depends on load in EX.
- redirect_ex  in  1  branch/jump resolved taken in EX; PC is redirected.
- mdu_req_ex  in  1  EX holds a mul/div instruction.
- mdu_done  in  1  one-cycle pulse: MDU result valid.
- mem_busy  in  1  data memory not ready; MEM must hold.
- mdu_start  out  1  one-cycle pulse starting the MDU.
- pc_we  out  1  PC write enable.
- if_id_we  out  1  IF/ID write enable.
- id_ex_we  out  1  ID/EX write enable.
- ex_mem_we  out  1  EX/MEM write enable.
- mem_wb_we  out  1  MEM/WB write enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load NOP into ID/EX.
- ex_mem_flush  out  1  load NOP into EX/MEM.
- busy  out  1  state != RUN.
- load_stall_cnt  out  CNT_W  cycles spent in load-use stall.
- mdu_stall_cnt  out  CNT_W  cycles spent waiting for the MDU.
- mem_stall_cnt  out  CNT_W  cycles with mem_busy=1.

Behaviour:
- Reset (rst_n=0, async):
  - state=RUN, all counters=0, done_seen=0, stall counter=0.
  - All *_we, all flushes and mdu_start are forced 0 (outputs gated by rst_n).
- States: RUN, LOAD_STALL, MDU_WAIT.
- Priority 1, mem_busy=1 in any state:
  - All *_we=0, all flushes=0, mdu_start=0.
  - State and stall counter frozen; mem_stall_cnt++.
- RUN, with mem_busy=0:
  - redirect_ex=1: all we=1, if_id_flush=1, id_ex_flush=1; stay RUN. load_stop is ignored because the ID instruction is squashed.
  - else mdu_req_ex=1: mdu_start=1; pc_we, if_id_we, id_ex_we=0; ex_mem_flush=1; -> MDU_WAIT.
  - else load_stop=1: pc_we=if_id_we=0; id_ex_flush=1; stall counter=LOAD_STALL_CYC-1. Go to LOAD_STALL if LOAD_STALL_CYC>1, else stay RUN. load_stall_cnt++.
  - else: all we=1, no flush.
- LOAD_STALL:
  - pc_we=if_id_we=0; id_ex_flush=1; load_stall_cnt++.
  - Decrement the stall counter; at 1, return to RUN.
  - Redirect cannot occur here (EX holds a bubble).
- MDU_WAIT:
  - pc_we, if_id_we, id_ex_we=0; ex_mem_flush=1; mdu_stall_cnt++.
  - mdu_done=1, or done_seen=1: all we=1, no flush; clear done_seen; -> RUN.
- mdu_done arriving while mem_busy=1: set done_seen; it is consumed on the first cycle with mem_busy=0.
- mdu_start fires exactly once per MDU instruction. It is never re-issued while in MDU_WAIT.
- mem_wb_we=1 whenever mem_busy=0 and rst_n=1.
- Counters saturate at all-ones and never wrap.
- Outputs are combinational from state, registers and inputs. No registered-output latency.
- Transitions occur on the rising clk edge.

Decomposition:
- Shared package: state encoding (RUN=2'd0, LOAD_STALL=2'd1, MDU_WAIT=2'd2) and a NOP-instruction constant used by the flush muxes.
- One sub-module: sat_counter, parameterised CNT_W, with inc input and async active-low clear. Instantiated three times.

Test Plan:
- Reset mid-MDU_WAIT: drop rst_n -> all outputs 0 immediately. After release: state RUN, counters 0, no mdu_start.
- load_stop=1 for 1 cycle, LOAD_STALL_CYC=1 -> one cycle with pc_we=0, if_id_we=0, id_ex_flush=1; next cycle all we=1; load_stall_cnt=1.
- load_stop and redirect_ex both 1 -> if_id_flush=1, id_ex_flush=1, pc_we=1; load_stall_cnt unchanged.
- mdu_req_ex=1, mdu_done after 4 cycles -> mdu_start high for exactly 1 cycle; ex_mem_flush=1 for 4 cycles; mdu_stall_cnt=4; RUN on the 5th cycle.
- mdu_done pulses while mem_busy=1 for 3 cycles -> all we=0 during those 3 cycles; on mem_busy=0 all we=1 and state returns to RUN; mem_stall_cnt=3.
- CNT_W=4 with 20 load stalls -> load_stall_cnt holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state encoding,
// the NOP word loaded by the stage flushes, and stall-count setup.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MDU_WAIT   = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Remaining bubble cycles after the first one issued from RUN.
  function automatic logic [2:0] stall_init(input int unsigned cyc);
    return 3'(cyc - 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for stall-cycle performance reporting.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: turns load-use, redirect,
// MDU and data-memory wait conditions into stage enables and flushes.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYC = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_stop,
  input  logic             redirect_ex,
  input  logic             mdu_req_ex,
  input  logic             mdu_done,
  input  logic             mem_busy,
  output logic             mdu_start,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             busy,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] mdu_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt
);

  state_e      r_state, w_nxt_state;
  logic [2:0]  r_stall_cnt, w_nxt_stall;
  logic        r_done_seen, w_nxt_done;
  logic        w_pc_we, w_if_id_we, w_id_ex_we, w_ex_mem_we, w_mem_wb_we;
  logic        w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mdu_start;
  logic        w_load_inc, w_mdu_inc;

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_stall    = r_stall_cnt;
    w_nxt_done     = r_done_seen;
    w_pc_we        = 1'b0;
    w_if_id_we     = 1'b0;
    w_id_ex_we     = 1'b0;
    w_ex_mem_we    = 1'b0;
    w_mem_wb_we    = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    w_mdu_start    = 1'b0;
    w_load_inc     = 1'b0;
    w_mdu_inc      = 1'b0;
    if (mem_busy) begin
      // Whole pipe frozen; remember an MDU completion so it is not lost.
      if (r_state == MDU_WAIT && mdu_done)
        w_nxt_done = 1'b1;
    end else begin
      w_mem_wb_we = 1'b1;
      unique case (r_state)
        RUN: begin
          if (redirect_ex) begin
            {w_pc_we, w_if_id_we, w_id_ex_we, w_ex_mem_we} = '1;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (mdu_req_ex) begin
            w_mdu_start    = 1'b1;
            w_ex_mem_we    = 1'b1;
            w_ex_mem_flush = 1'b1;
            w_nxt_state    = MDU_WAIT;
          end else if (load_stop) begin
            w_id_ex_we    = 1'b1;
            w_ex_mem_we   = 1'b1;
            w_id_ex_flush = 1'b1;
            w_load_inc    = 1'b1;
            w_nxt_stall   = stall_init(LOAD_STALL_CYC);
            w_nxt_state   = (LOAD_STALL_CYC > 1) ? LOAD_STALL : RUN;
          end else begin
            {w_pc_we, w_if_id_we, w_id_ex_we, w_ex_mem_we} = '1;
          end
        end
        LOAD_STALL: begin
          w_id_ex_we    = 1'b1;
          w_ex_mem_we   = 1'b1;
          w_id_ex_flush = 1'b1;
          w_load_inc    = 1'b1;
          if (r_stall_cnt <= 3'd1)
            w_nxt_state = RUN;
          else
            w_nxt_stall = r_stall_cnt - 3'd1;
        end
        MDU_WAIT: begin
          w_mdu_inc = 1'b1;
          if (mdu_done || r_done_seen) begin
            {w_pc_we, w_if_id_we, w_id_ex_we, w_ex_mem_we} = '1;
            w_nxt_done  = 1'b0;
            w_nxt_state = RUN;
          end else begin
            w_ex_mem_we    = 1'b1;
            w_ex_mem_flush = 1'b1;
          end
        end
        default: w_nxt_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_done_seen <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_stall_cnt <= w_nxt_stall;
      r_done_seen <= w_nxt_done;
    end
  end

  assign pc_we        = w_pc_we        & rst_n;
  assign if_id_we     = w_if_id_we     & rst_n;
  assign id_ex_we     = w_id_ex_we     & rst_n;
  assign ex_mem_we    = w_ex_mem_we    & rst_n;
  assign mem_wb_we    = w_mem_wb_we    & rst_n;
  assign if_id_flush  = w_if_id_flush  & rst_n;
  assign id_ex_flush  = w_id_ex_flush  & rst_n;
  assign ex_mem_flush = w_ex_mem_flush & rst_n;
  assign mdu_start    = w_mdu_start    & rst_n;
  assign busy         = (r_state != RUN);

  sat_counter #(.CNT_W(CNT_W)) u_load_cnt (
    .clk(clk), .rst_n(rst_n), .i_inc(w_load_inc), .o_cnt(load_stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_mdu_cnt (
    .clk(clk), .rst_n(rst_n), .i_inc(w_mdu_inc), .o_cnt(mdu_stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_mem_cnt (
    .clk(clk), .rst_n(rst_n), .i_inc(mem_busy), .o_cnt(mem_stall_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table on the default
// configuration plus hand sequences for reset and multi-cycle load stalls.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        load_stop, redirect_ex, mdu_req_ex, mdu_done, mem_busy;
  logic        mdu_start, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, busy;
  logic [31:0] load_cnt, mdu_cnt, mem_cnt;

  logic        ld2, mb2, zero2;
  logic        s2, pc2, ifid2, idex2, exmem2, memwb2, iff2, idf2, exf2, busy2;
  logic [3:0]  lc2, mc2, sc2;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pipe_hazard_ctrl #(.LOAD_STALL_CYC(1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .load_stop(load_stop), .redirect_ex(redirect_ex),
    .mdu_req_ex(mdu_req_ex), .mdu_done(mdu_done), .mem_busy(mem_busy),
    .mdu_start(mdu_start), .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .busy(busy),
    .load_stall_cnt(load_cnt), .mdu_stall_cnt(mdu_cnt), .mem_stall_cnt(mem_cnt)
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYC(3), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_stop(ld2), .redirect_ex(zero2),
    .mdu_req_ex(zero2), .mdu_done(zero2), .mem_busy(mb2),
    .mdu_start(s2), .pc_we(pc2), .if_id_we(ifid2), .id_ex_we(idex2),
    .ex_mem_we(exmem2), .mem_wb_we(memwb2), .if_id_flush(iff2),
    .id_ex_flush(idf2), .ex_mem_flush(exf2), .busy(busy2),
    .load_stall_cnt(lc2), .mdu_stall_cnt(mc2), .mem_stall_cnt(sc2)
  );

  // Output vector: {start, pc, ifid, idex, exmem, memwb, iff, idf, exf, busy}
  localparam logic [9:0] E_ZERO  = 10'b0_00000_000_0;
  localparam logic [9:0] E_ALL   = 10'b0_11111_000_0;
  localparam logic [9:0] E_LOAD  = 10'b0_00111_010_0;
  localparam logic [9:0] E_LSTL  = 10'b0_00111_010_1;
  localparam logic [9:0] E_REDIR = 10'b0_11111_110_0;
  localparam logic [9:0] E_START = 10'b1_00011_001_0;
  localparam logic [9:0] E_WAIT  = 10'b0_00011_001_1;
  localparam logic [9:0] E_DONE  = 10'b0_11111_000_1;
  localparam logic [9:0] E_HOLDW = 10'b0_00000_000_1;
  localparam logic [9:0] E_HOLDR = 10'b0_00000_000_0;

  typedef struct {
    logic [4:0]  in;   // {load_stop, redirect_ex, mdu_req_ex, mdu_done, mem_busy}
    logic [9:0]  exp;
    int unsigned l, m, s;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic [4:0] in, logic [9:0] exp,
                              int unsigned l, int unsigned m, int unsigned s);
    vec_t v;
    v.in = in; v.exp = exp; v.l = l; v.m = m; v.s = s;
    return v;
  endfunction

  function automatic logic [9:0] outs1();
    return {mdu_start, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
            if_id_flush, id_ex_flush, ex_mem_flush, busy};
  endfunction

  function automatic logic [9:0] outs2();
    return {s2, pc2, ifid2, idex2, exmem2, memwb2, iff2, idf2, exf2, busy2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = mk(5'b00000, E_ALL,   0, 0, 0);
    vecs[1]  = mk(5'b10000, E_LOAD,  0, 0, 0);
    vecs[2]  = mk(5'b00000, E_ALL,   1, 0, 0);
    vecs[3]  = mk(5'b11000, E_REDIR, 1, 0, 0);
    vecs[4]  = mk(5'b00000, E_ALL,   1, 0, 0);
    vecs[5]  = mk(5'b00100, E_START, 1, 0, 0);
    vecs[6]  = mk(5'b00100, E_WAIT,  1, 0, 0);
    vecs[7]  = mk(5'b00100, E_WAIT,  1, 1, 0);
    vecs[8]  = mk(5'b00100, E_WAIT,  1, 2, 0);
    vecs[9]  = mk(5'b00110, E_DONE,  1, 3, 0);
    vecs[10] = mk(5'b00000, E_ALL,   1, 4, 0);
    vecs[11] = mk(5'b00100, E_START, 1, 4, 0);
    vecs[12] = mk(5'b00111, E_HOLDW, 1, 4, 0);
    vecs[13] = mk(5'b00101, E_HOLDW, 1, 4, 1);
    vecs[14] = mk(5'b00101, E_HOLDW, 1, 4, 2);
    vecs[15] = mk(5'b00100, E_DONE,  1, 4, 3);
    vecs[16] = mk(5'b00000, E_ALL,   1, 5, 3);
    vecs[17] = mk(5'b10001, E_HOLDR, 1, 5, 3);
    vecs[18] = mk(5'b10000, E_LOAD,  1, 5, 4);
    vecs[19] = mk(5'b00000, E_ALL,   2, 5, 4);
    vecs[20] = mk(5'b00100, E_START, 2, 5, 4);
    vecs[21] = mk(5'b00100, E_WAIT,  2, 5, 4);

    rst_n = 1'b0;
    {load_stop, redirect_ex, mdu_req_ex, mdu_done, mem_busy} = '0;
    ld2 = 1'b0; mb2 = 1'b0; zero2 = 1'b0;
    #2;
    chk("reset_outs", 32'(outs1()), 32'(E_ZERO));
    chk("reset_cnts", load_cnt | mdu_cnt | mem_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      {load_stop, redirect_ex, mdu_req_ex, mdu_done, mem_busy} = vecs[i].in;
      #1;
      chk($sformatf("v%0d_outs", i), 32'(outs1()), 32'(vecs[i].exp));
      chk($sformatf("v%0d_load_cnt", i), load_cnt, vecs[i].l);
      chk($sformatf("v%0d_mdu_cnt", i), mdu_cnt, vecs[i].m);
      chk($sformatf("v%0d_mem_cnt", i), mem_cnt, vecs[i].s);
    end

    // Asynchronous reset while sitting in MDU_WAIT with the request still up.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_outs", 32'(outs1()), 32'(E_ZERO));
    chk("midwait_rst_cnts", load_cnt | mdu_cnt | mem_cnt, 32'd0);
    {load_stop, redirect_ex, mdu_req_ex, mdu_done, mem_busy} = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_outs", 32'(outs1()), 32'(E_ALL));
    @(negedge clk);
    #1;
    chk("post_rst_idle", 32'(outs1()), 32'(E_ALL));
    chk("post_rst_mdu_cnt", mdu_cnt, 32'd0);

    // Three-cycle load stall with a memory wait in the middle.
    @(negedge clk); ld2 = 1'b1; #1;
    chk("ls3_c0_outs", 32'(outs2()), 32'(E_LOAD));
    chk("ls3_c0_cnt", 32'(lc2), 32'd0);
    @(negedge clk); ld2 = 1'b0; #1;
    chk("ls3_c1_outs", 32'(outs2()), 32'(E_LSTL));
    chk("ls3_c1_cnt", 32'(lc2), 32'd1);
    @(negedge clk); mb2 = 1'b1; #1;
    chk("ls3_c2_outs", 32'(outs2()), 32'(E_HOLDW));
    chk("ls3_c2_cnt", 32'(lc2), 32'd2);
    @(negedge clk); mb2 = 1'b0; #1;
    chk("ls3_c3_outs", 32'(outs2()), 32'(E_LSTL));
    chk("ls3_c3_mem_cnt", 32'(sc2), 32'd1);
    @(negedge clk); #1;
    chk("ls3_c4_outs", 32'(outs2()), 32'(E_ALL));
    chk("ls3_c4_cnt", 32'(lc2), 32'd3);

    // 20 more load stalls (60 cycles) must pin the 4-bit counter at 15.
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); ld2 = 1'b1;
      @(negedge clk); ld2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    #1;
    chk("sat_cnt", 32'(lc2), 32'd15);
    chk("sat_outs", 32'(outs2()), 32'(E_ALL));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
